// File: rtl/sw_ctrl_pkg.sv
// Shared types and default constants for the switch debounce controller.
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT
  } state_e;

  localparam int TICK_DIV_DEF = 50000;
  localparam int DEB_CNT_DEF  = 10;

endpackage

// File: rtl/sw_tick_gen.sv
// Free-running sample prescaler: one-cycle tick every TICK_DIV clocks while enabled.
module sw_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // Disable parks the counter at 0 so re-enabling always starts a full period.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                     count <= '0;
    else if (!i_en || count == LAST) count <= '0;
    else                             count <= count + ONE;
  end

  assign o_tick = i_en && (count == LAST);

endmodule

// File: rtl/sw_debounce_ctrl.sv
// Switch input path: 2-flop synchroniser, tick-sampled settle FSM, sticky change
// flags with a req/ack clear, and a registered level interrupt.
module sw_debounce_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int SW_W     = 32,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEB_CNT  = DEB_CNT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [SW_W-1:0] i_io_sw,
  input  logic            i_en,
  input  logic [SW_W-1:0] i_irq_en,
  input  logic            i_clr_req,
  input  logic [SW_W-1:0] i_clr_mask,
  output logic            o_clr_ack,
  output logic [SW_W-1:0] o_sw_stable,
  output logic [SW_W-1:0] o_sw_changed,
  output logic            o_irq,
  output logic            o_busy
);

  localparam int            CW      = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SW_W-1:0] sync_d, sync_q;
  logic            tick;
  state_e          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [SW_W-1:0] cand, cand_n;
  logic [SW_W-1:0] stable_n, chg_set, changed_n;
  logic            clr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_d <= '0;
      sync_q <= '0;
    end else begin
      sync_d <= i_io_sw;
      sync_q <= sync_d;
    end
  end

  sw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_en),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cand         <= '0;
      o_sw_stable  <= '0;
      o_sw_changed <= '0;
      o_clr_ack    <= 1'b0;
      o_irq        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cand         <= cand_n;
      o_sw_stable  <= stable_n;
      o_sw_changed <= changed_n;
      o_clr_ack    <= clr;
      o_irq        <= |(o_sw_changed & i_irq_en);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cand_n   = cand;
    stable_n = o_sw_stable;
    chg_set  = '0;
    if (!i_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (tick && sync_q != o_sw_stable) begin
            cand_n  = sync_q;
            cnt_n   = CNT_ONE;
            state_n = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // A full run commits without waiting for another tick.
          if (cnt == CNT_MAX) begin
            state_n = ST_COMMIT;
          end else if (tick) begin
            if (sync_q == cand) begin
              cnt_n = cnt + CNT_ONE;
            end else if (sync_q == o_sw_stable) begin
              cnt_n   = '0;
              state_n = ST_IDLE;
            end else begin
              cand_n = sync_q;
              cnt_n  = CNT_ONE;
            end
          end
        end
        ST_COMMIT: begin
          stable_n = cand;
          chg_set  = o_sw_stable ^ cand;
          cnt_n    = '0;
          state_n  = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // A clear landing on a commit still keeps the freshly changed bits.
    clr       = i_clr_req && !o_clr_ack;
    changed_n = (clr ? (o_sw_changed & ~i_clr_mask) : o_sw_changed) | chg_set;
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Bench for sw_debounce_ctrl: vector table, directed corner cases and random
// stimulus, all checked cycle by cycle against a run-length debounce model.
module tb_sw_debounce_ctrl;
  localparam int SW_W = 32;
  localparam int TD   = 4;
  localparam int DEB  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en, clr_req, clr_ack, irq, busy;
  logic [SW_W-1:0] io_sw, irq_en, clr_mask, stable, changed;

  sw_debounce_ctrl #(.SW_W(SW_W), .TICK_DIV(TD), .DEB_CNT(DEB)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_io_sw      (io_sw),
    .i_en         (en),
    .i_irq_en     (irq_en),
    .i_clr_req    (clr_req),
    .i_clr_mask   (clr_mask),
    .o_clr_ack    (clr_ack),
    .o_sw_stable  (stable),
    .o_sw_changed (changed),
    .o_irq        (irq),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: sync history, tick phase, length of the current run of
  // identical non-stable samples, and a pending-commit countdown.
  logic [SW_W-1:0] m_s1, m_s2, m_stable, m_changed, m_rval, m_pval;
  int              m_pc, m_run, m_pend;
  logic            m_ack, m_irq;

  typedef struct {
    logic [31:0] sw;
    logic        en;
    logic [31:0] ie;
    logic        req;
    logic [31:0] mask;
    int          cycles;
    logic [31:0] e_stable;
    logic [31:0] e_changed;
    logic        e_irq;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_changed = '0; m_rval = '0; m_pval = '0;
    m_pc = 0; m_run = 0; m_pend = 0; m_ack = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [SW_W-1:0] sq, bits;
    logic            tk, clr;
    int              p;
    sq   = m_s2;
    tk   = en && (m_pc == TD - 1);
    m_s2 = m_s1;
    m_s1 = io_sw;
    m_pc = en ? (m_pc + 1) % TD : 0;
    bits = '0;
    p    = m_pend;
    if (p > 0) begin
      if (!en) m_pend = 0;
      else begin
        m_pend = p - 1;
        if (p == 1) begin
          bits     = m_stable ^ m_pval;
          m_stable = m_pval;
        end
      end
    end else if (tk) begin
      if (m_run > 0 && sq == m_rval) m_run++;
      else if (sq == m_stable)       m_run = 0;
      else begin m_rval = sq; m_run = 1; end
      if (m_run == DEB) begin m_pend = 2; m_pval = m_rval; m_run = 0; end
    end
    if (!en) m_run = 0;
    clr       = clr_req && !m_ack;
    m_irq     = |(m_changed & irq_en);
    m_changed = (clr ? (m_changed & ~clr_mask) : m_changed) | bits;
    m_ack     = clr;
  endtask

  task automatic model_check();
    logic [66:0] act, exp;
    act = {stable, changed, irq, clr_ack, busy};
    exp = {m_stable, m_changed, m_irq, m_ack, (m_run > 0 || m_pend > 0)};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model: got stb=%h chg=%h irq=%b ack=%b busy=%b expected stb=%h chg=%h irq=%b ack=%b busy=%b at %0t",
               stable, changed, irq, clr_ack, busy, m_stable, m_changed, m_irq, m_ack,
               (m_run > 0 || m_pend > 0), $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk({tag, "_stable"},  stable,        '0);
    chk({tag, "_changed"}, changed,       '0);
    chk({tag, "_irq"},     32'(irq),      '0);
    chk({tag, "_ack"},     32'(clr_ack),  '0);
    chk({tag, "_busy"},    32'(busy),     '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic saw_busy, saw_one, done;
    int   n;

    vecs[0] = '{32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        12, 32'h0,  32'h0,  1'b0};
    vecs[1] = '{32'hA,  1'b0, 32'h0,  1'b0, 32'h0,        12, 32'h0,  32'h0,  1'b0};
    vecs[2] = '{32'hA,  1'b1, 32'h0,  1'b0, 32'h0,        20, 32'hA,  32'hA,  1'b0};
    vecs[3] = '{32'hA,  1'b1, 32'h2,  1'b0, 32'h0,         4, 32'hA,  32'hA,  1'b1};
    vecs[4] = '{32'hA,  1'b1, 32'h2,  1'b1, 32'hFFFFFFFF,  3, 32'hA,  32'h0,  1'b0};
    vecs[5] = '{32'hF0, 1'b1, 32'h10, 1'b0, 32'h0,        20, 32'hF0, 32'hFA, 1'b1};
    vecs[6] = '{32'hF0, 1'b0, 32'h10, 1'b0, 32'h0,        12, 32'hF0, 32'hFA, 1'b1};
    vecs[7] = '{32'h0,  1'b1, 32'h10, 1'b0, 32'h0,        20, 32'h0,  32'hFA, 1'b1};

    rst = 1'b1; en = 1'b0; io_sw = '0; irq_en = '0; clr_req = 1'b0; clr_mask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      io_sw = vecs[v].sw; en = vecs[v].en; irq_en = vecs[v].ie;
      clr_req = vecs[v].req; clr_mask = vecs[v].mask;
      repeat (vecs[v].cycles) cyc();
      chk($sformatf("vec%0d_stable", v),  stable,       vecs[v].e_stable);
      chk($sformatf("vec%0d_changed", v), changed,      vecs[v].e_changed);
      chk($sformatf("vec%0d_irq", v),     32'(irq),     32'(vecs[v].e_irq));
    end
    clr_req = 1'b0; irq_en = '0;

    // Bounce: one tick of 0x5, then back to 0.
    reset_mid("rst_a");
    en = 1'b1; io_sw = '0;
    for (int r = 0; r < 3; r++) begin
      io_sw = 32'h5; repeat (4) cyc();
      io_sw = 32'h0; repeat (8) cyc();
      chk($sformatf("bounce%0d_busy", r),    32'(busy), '0);
      chk($sformatf("bounce%0d_stable", r),  stable,    '0);
      chk($sformatf("bounce%0d_changed", r), changed,   '0);
    end

    // Candidate switch: 0x1 for two ticks, then 0x3 held.
    reset_mid("rst_b");
    en = 1'b1; io_sw = 32'h1;
    repeat (8) cyc();
    io_sw = 32'h3; saw_one = 1'b0; n = 0;
    while (stable == '0 && n < 24) begin cyc(); n++; end
    if (stable == 32'h1) saw_one = 1'b1;
    chk("cand_stable",  stable,       32'h3);
    chk("cand_changed", changed,      32'h3);
    chk("cand_no_1",    32'(saw_one), '0);

    // Clean change with latency window.
    reset_mid("rst_c");
    en = 1'b1; io_sw = '0;
    repeat (6) cyc();
    io_sw = 32'h5; n = 0; saw_busy = 1'b0;
    while (stable != 32'h5 && n < 20) begin
      cyc(); n++;
      if (busy) saw_busy = 1'b1;
    end
    chk("clean_latency_ok", 32'(n >= 10 && n <= 16), 32'h1);
    chk("clean_changed",    changed,                 32'h5);
    chk("clean_busy_seen",  32'(saw_busy),           32'h1);

    // IRQ and clear handshake.
    irq_en = 32'h4;
    cyc(); cyc();
    chk("irq_set", 32'(irq), 32'h1);
    clr_req = 1'b1; clr_mask = 32'h4;
    cyc();
    chk("clr_ack_hi",   32'(clr_ack), 32'h1);
    chk("clr_changed",  changed,      32'h1);
    clr_req = 1'b0;
    cyc();
    chk("clr_ack_lo", 32'(clr_ack), '0);
    chk("irq_clear",  32'(irq),     '0);

    // Clear landing in the commit cycle of 0x5 -> 0x7.
    io_sw = 32'h7; n = 0; done = 1'b0;
    while (!done && n < 24) begin
      cyc(); n++;
      if (m_pend == 1) done = 1'b1;
    end
    chk("simul_commit_seen", 32'(done), 32'h1);
    clr_req = 1'b1; clr_mask = 32'hF;
    cyc();
    clr_req = 1'b0;
    chk("simul_changed", changed,      32'h2);
    chk("simul_stable",  stable,       32'h7);
    chk("simul_ack",     32'(clr_ack), 32'h1);
    cyc();

    // Random traffic.
    reset_mid("rst_d");
    begin
      int hold = 0;
      for (int i = 0; i < 800; i++) begin
        if (hold == 0) begin
          case ($urandom_range(0, 4))
            0:       io_sw = 32'h0;
            1:       io_sw = 32'h1;
            2:       io_sw = 32'h3;
            3:       io_sw = 32'h5;
            default: io_sw = $urandom;
          endcase
          hold = $urandom_range(1, 16);
        end
        hold--;
        en       = ($urandom_range(0, 39) != 0);
        irq_en   = $urandom;
        clr_req  = ($urandom_range(0, 7) == 0);
        clr_mask = $urandom;
        cyc();
      end
    end

    // Reset in the middle of a settle with all switches high.
    clr_req = 1'b0; en = 1'b1; irq_en = '1; io_sw = 32'h5A; n = 0;
    while (stable != 32'h5A && n < 24) begin cyc(); n++; end
    chk("pre_rst_stable", stable, 32'h5A);
    io_sw = 32'hFFFF_FFFF; n = 0;
    while (!busy && n < 12) begin cyc(); n++; end
    chk("pre_rst_busy", 32'(busy), 32'h1);
    en = 1'b0;
    reset_mid("rst_e");
    repeat (10) cyc();
    chk("post_rst_stable",  stable,  '0);
    chk("post_rst_changed", changed, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
